// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and state encoding for the mux16 scan sequencer.
package mux_scan_ctrl_pkg;

    localparam int SEL_W     = 4;
    localparam int NCH       = 16;
    localparam int CNT_W     = 4;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    function automatic bit dwell_legal(input int dwell);
        return (dwell >= DWELL_MIN) && (dwell <= DWELL_MAX);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle of the select/sample lines toward mux16 and the downstream word handshake.
interface mux_scan_ctrl_if;
    import mux_scan_ctrl_pkg::*;

    logic             start;
    logic [SEL_W-1:0] sel;
    logic             y_in;
    logic             busy;
    logic [NCH-1:0]   dout;
    logic             dout_valid;
    logic             dout_ready;

    modport slave (
        input  start, y_in, dout_ready,
        output sel, busy, dout, dout_valid
    );

    modport master (
        output start, y_in, dout_ready,
        input  sel, busy, dout, dout_valid
    );

endinterface

// File: rtl/mux_scan_ctrl_scan_dwell_timer.sv
// Per-channel dwell counter: tick marks the last cycle sel is held; clr forces it back to zero.
module scan_dwell_timer
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    generate
        if (!dwell_legal(DWELL)) begin : g_bad_dwell
            $error("scan_dwell_timer: DWELL out of range 1..16");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Wraps to zero on tick so the count never exceeds DWELL-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around mux16: steps sel 0..15, samples y_in per channel, hands off a 16-bit word.
// Define MUX_SCAN_CONT_EN for continuous rescanning after the first start.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    mux_scan_ctrl_if.slave   bus
);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   shadow_q, shadow_d;
    logic [NCH-1:0]   dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             timer_clr;
    logic             timer_en;
    logic             dwell_tick;

    scan_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .tick (dwell_tick)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        timer_clr    = 1'b1;
        timer_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.start) begin
                    state_d = SCAN;
                end
            end

            SCAN: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (dwell_tick) begin
                    shadow_d[sel_q] = bus.y_in;
                    // Last channel goes straight into dout; shadow bit 15 is never read.
                    if (sel_q == SEL_W'(NCH - 1)) begin
                        dout_d       = {bus.y_in, shadow_q[NCH-2:0]};
                        dout_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end

            DONE: begin
                if (bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    sel_d        = '0;
`ifdef MUX_SCAN_CONT_EN
                    state_d      = SCAN;
`else
                    state_d      = IDLE;
`endif
                end
            end

            default: begin
                state_d      = IDLE;
                sel_d        = '0;
                dout_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl; mux16 is modelled as y = i[sel] for a DWELL=1 and a DWELL=3 instance.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i1;
    logic [15:0] i3;
    int          n_checks = 0;
    int          n_errors = 0;

    mux_scan_ctrl_if bus1 ();
    mux_scan_ctrl_if bus3 ();

    assign bus1.y_in = i1[bus1.sel];
    assign bus3.y_in = i3[bus3.sel];

    mux_scan_ctrl #(.DWELL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mux_scan_ctrl #(.DWELL(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b0; bus1.dout_ready = 1'b0;
        bus3.start = 1'b0; bus3.dout_ready = 1'b0;
        i1 = 16'h0000; i3 = 16'h0000;
        step(); step();
        n_checks++; if (bus1.sel !== 4'd0) begin n_errors++; $display("FAIL reset_sel: got %0d want 0", bus1.sel); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
        n_checks++; if (bus1.dout !== 16'h0000) begin n_errors++; $display("FAIL reset_dout: got %h want 0000", bus1.dout); end
        n_checks++; if (bus1.dout_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus1.dout_valid); end
        n_checks++; if (bus3.busy !== 1'b0 || bus3.dout_valid !== 1'b0) begin n_errors++; $display("FAIL reset_dut3: busy %b valid %b want 0 0", bus3.busy, bus3.dout_valid); end
        rst = 1'b0;
        step();
        n_checks++; if (bus1.busy !== 1'b0) begin n_errors++; $display("FAIL idle_after_reset: busy %b want 0", bus1.busy); end
    endtask

`ifndef MUX_SCAN_CONT_EN
    task automatic test_single_scan();
        i1 = 16'hA5C3;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        n_checks++; if (bus1.busy !== 1'b1 || bus1.sel !== 4'd0) begin n_errors++; $display("FAIL single_start: busy %b sel %0d want 1 0", bus1.busy, bus1.sel); end
        for (int j = 1; j < 16; j++) begin
            step();
            n_checks++; if (bus1.sel !== 4'(j) || bus1.dout_valid !== 1'b0) begin n_errors++; $display("FAIL single_sel: sel %0d valid %b want %0d 0", bus1.sel, bus1.dout_valid, j); end
        end
        step();
        n_checks++; if (bus1.dout_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1 at k+16", bus1.dout_valid); end
        n_checks++; if (bus1.dout !== 16'hA5C3) begin n_errors++; $display("FAIL single_dout: got %h want a5c3", bus1.dout); end
        n_checks++; if (bus1.sel !== 4'd15 || bus1.busy !== 1'b1) begin n_errors++; $display("FAIL single_done: sel %0d busy %b want 15 1", bus1.sel, bus1.busy); end
        bus1.dout_ready = 1'b1;
        step();
        bus1.dout_ready = 1'b0;
        n_checks++; if (bus1.dout_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.sel !== 4'd0) begin n_errors++; $display("FAIL single_handshake: valid %b busy %b sel %0d want 0 0 0", bus1.dout_valid, bus1.busy, bus1.sel); end
        n_checks++; if (bus1.dout !== 16'hA5C3) begin n_errors++; $display("FAIL single_dout_kept: got %h want a5c3", bus1.dout); end
    endtask

    task automatic test_dwell();
        i3 = 16'h00FF;
        bus3.start = 1'b1;
        step();
        bus3.start = 1'b0;
        for (int m = 0; m < 48; m++) begin
            n_checks++; if (bus3.sel !== 4'(m / 3) || bus3.dout_valid !== 1'b0) begin n_errors++; $display("FAIL dwell_sel: cycle %0d sel %0d valid %b want %0d 0", m, bus3.sel, bus3.dout_valid, m / 3); end
            step();
        end
        n_checks++; if (bus3.dout_valid !== 1'b1 || bus3.dout !== 16'h00FF) begin n_errors++; $display("FAIL dwell_word: valid %b dout %h want 1 00ff", bus3.dout_valid, bus3.dout); end
        bus3.dout_ready = 1'b1;
        step();
        bus3.dout_ready = 1'b0;
        n_checks++; if (bus3.busy !== 1'b0 || bus3.dout_valid !== 1'b0) begin n_errors++; $display("FAIL dwell_handshake: busy %b valid %b want 0 0", bus3.busy, bus3.dout_valid); end
    endtask

    task automatic test_backpressure();
        i1 = 16'h5A3C;
        bus1.dout_ready = 1'b1;
        step();
        n_checks++; if (bus1.busy !== 1'b0) begin n_errors++; $display("FAIL bp_ready_idle: busy %b want 0", bus1.busy); end
        bus1.dout_ready = 1'b0;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int j = 0; j < 16; j++) step();
        for (int c = 0; c < 10; c++) begin
            bus1.start = c[0];
            n_checks++; if (bus1.dout_valid !== 1'b1 || bus1.dout !== 16'h5A3C || bus1.sel !== 4'd15) begin n_errors++; $display("FAIL bp_hold: cycle %0d valid %b dout %h sel %0d want 1 5a3c 15", c, bus1.dout_valid, bus1.dout, bus1.sel); end
            step();
        end
        bus1.start = 1'b0;
        bus1.dout_ready = 1'b1;
        step();
        bus1.dout_ready = 1'b0;
        n_checks++; if (bus1.dout_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.sel !== 4'd0) begin n_errors++; $display("FAIL bp_release: valid %b busy %b sel %0d want 0 0 0", bus1.dout_valid, bus1.busy, bus1.sel); end
        step();
        n_checks++; if (bus1.busy !== 1'b0) begin n_errors++; $display("FAIL bp_no_queue: busy %b want 0", bus1.busy); end
    endtask

    task automatic test_reset_mid_scan();
        i1 = 16'h1357;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int j = 0; j < 7; j++) step();
        n_checks++; if (bus1.sel !== 4'd7) begin n_errors++; $display("FAIL rst_mid_pre: sel %0d want 7", bus1.sel); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus1.sel !== 4'd0 || bus1.busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_async: sel %0d busy %b want 0 0", bus1.sel, bus1.busy); end
        n_checks++; if (bus1.dout !== 16'h0000 || bus1.dout_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_out: dout %h valid %b want 0000 0", bus1.dout, bus1.dout_valid); end
        rst = 1'b0;
        step();
        n_checks++; if (bus1.busy !== 1'b0 || bus1.dout_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_idle: busy %b valid %b want 0 0", bus1.busy, bus1.dout_valid); end
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int j = 0; j < 15; j++) step();
        n_checks++; if (bus1.dout_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_early: valid %b want 0 at k+15", bus1.dout_valid); end
        step();
        n_checks++; if (bus1.dout_valid !== 1'b1 || bus1.dout !== 16'h1357) begin n_errors++; $display("FAIL rst_mid_rescan: valid %b dout %h want 1 1357", bus1.dout_valid, bus1.dout); end
        bus1.dout_ready = 1'b1;
        step();
        bus1.dout_ready = 1'b0;
    endtask

    task automatic test_input_change();
        i1 = 16'h1234;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int j = 0; j < 16; j++) step();
        n_checks++; if (bus1.dout_valid !== 1'b1 || bus1.dout !== 16'h1234) begin n_errors++; $display("FAIL chg_first: valid %b dout %h want 1 1234", bus1.dout_valid, bus1.dout); end
        bus1.dout_ready = 1'b1;
        bus1.start = 1'b1;
        step();
        bus1.dout_ready = 1'b0;
        bus1.start = 1'b0;
        n_checks++; if (bus1.busy !== 1'b0) begin n_errors++; $display("FAIL chg_start_on_handshake: busy %b want 0", bus1.busy); end
        step();
        n_checks++; if (bus1.busy !== 1'b0) begin n_errors++; $display("FAIL chg_still_idle: busy %b want 0", bus1.busy); end
        i1 = 16'hFFFF;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int j = 0; j < 16; j++) step();
        n_checks++; if (bus1.dout_valid !== 1'b1 || bus1.dout !== 16'hFFFF) begin n_errors++; $display("FAIL chg_second: valid %b dout %h want 1 ffff", bus1.dout_valid, bus1.dout); end
        bus1.dout_ready = 1'b1;
        step();
        bus1.dout_ready = 1'b0;
    endtask
`else
    task automatic test_continuous();
        i1 = 16'h8001;
        bus1.dout_ready = 1'b1;
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 15; j++) step();
            n_checks++; if (bus1.dout_valid !== 1'b0) begin n_errors++; $display("FAIL cont_early: word %0d valid %b want 0", w, bus1.dout_valid); end
            step();
            n_checks++; if (bus1.dout_valid !== 1'b1 || bus1.dout !== 16'h8001) begin n_errors++; $display("FAIL cont_word: word %0d valid %b dout %h want 1 8001", w, bus1.dout_valid, bus1.dout); end
            step();
            n_checks++; if (bus1.dout_valid !== 1'b0 || bus1.busy !== 1'b1 || bus1.sel !== 4'd0) begin n_errors++; $display("FAIL cont_rescan: word %0d valid %b busy %b sel %0d want 0 1 0", w, bus1.dout_valid, bus1.busy, bus1.sel); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MUX_SCAN_CONT_EN
        test_continuous();
`else
        test_single_scan();
        test_dwell();
        test_backpressure();
        test_reset_mid_scan();
        test_input_change();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Scan sequencer wrapped around the 16:1 bit mux.
- Drives the mux select lines through channels 0..15, samples the mux output bit for each channel, and assembles a 16-bit word.
- Presents the word downstream on a valid/ready handshake.
- Sits directly on both sides of mux16: `sel` feeds its `s` input, and its `y` output returns on `y_in`.

Parameters:
- DWELL, 1, cycles `sel` is held per channel before sampling; legal range 1..16.
- NCH, 16, channel count; fixed to 16, matches the 4-bit select.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- sel  out  4  registered select to mux s.
- y_in  in  1  mux output y for current sel.
- busy  out  1  high whenever state != IDLE.
- dout  out  16  assembled word; bit n = y_in sampled while sel==n.
- dout_valid  out  1  word available.
- dout_ready  in  1  downstream accepts word.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, dwell_cnt=0, shadow=0, dout=0, dout_valid=0, busy=0.
- Reset mid-scan aborts the scan with no partial output.
- States: IDLE, SCAN, DONE.
- IDLE:
  - sel=0.
  - start=1 at edge k -> SCAN, sel=0, dwell_cnt=0.
- SCAN, at each edge:
  - If dwell_cnt==DWELL-1: shadow[sel] <= y_in, dwell_cnt <= 0.
    - If sel==15: dout <= {y_in, shadow[14:0]}, dout_valid <= 1, -> DONE.
    - Else: sel <= sel+1.
  - Otherwise: dwell_cnt <= dwell_cnt+1.
- `sel` is registered, so y_in is stable for the whole cycle before sampling.
- Latency: dout_valid rises at edge k+16*DWELL. Each sel value is held exactly DWELL cycles.
- DONE:
  - dout and dout_valid held stable; sel stays 15.
  - dout_ready=1 at an edge -> dout_valid <= 0, sel <= 0, -> IDLE.
  - dout keeps its last value after handshake.
- start in SCAN or DONE is ignored; no queuing. start coincident with the handshake edge in DONE is ignored and must be reasserted in IDLE.
- dout_ready outside DONE has no effect.
- dwell_cnt is a 4-bit counter that never exceeds DWELL-1. sel wraps only through the return to IDLE, never by arithmetic overflow.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined (continuous scan):
  - The DONE handshake goes directly to SCAN with sel=0, with no start needed.
  - start is needed only for the first scan after reset.
  - busy stays high after the first start.
- Undefined: single-shot behaviour exactly as above.

Decomposition:
- Shared package holds:
  - SEL_W=4 and NCH=16.
  - State encoding constants: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - DWELL legal-range limits.
- One natural sub-module: scan_dwell_timer. It is the DWELL counter; it outputs a tick on its last cycle and is cleared by the FSM.
- FSM, sel counter and shadow register stay in the top.

Test Plan:
- Single scan (bench instantiates mux16 with i=16'hA5C3, DWELL=1, start pulse at edge k):
  - sel steps 0..15 one per cycle.
  - dout_valid rises at k+16 with dout=16'hA5C3.
  - busy high k+1..handshake.
- Dwell (DWELL=3, i=16'h00FF):
  - Each sel value held 3 cycles.
  - dout_valid at k+48, dout=16'h00FF.
- Backpressure (dout_ready low 10 cycles after valid):
  - dout, dout_valid and sel=15 held stable.
  - Extra start pulses ignored.
  - Ready pulse -> IDLE next edge, dout_valid=0.
- Reset mid-scan (assert rst when sel==7, asynchronously between edges):
  - sel, dout, dout_valid and busy go to 0 immediately.
  - Next start gives a full 16-channel scan with correct dout.
- Input change between scans (i=16'h1234, then i=16'hFFFF before second start):
  - Second dout=16'hFFFF.
  - start coincident with handshake edge is ignored.
- MUX_SCAN_CONT_EN defined, i=16'h8001, dout_ready tied high:
  - One start yields words 16'h8001 every 17 cycles (DWELL=1).
  - No further start needed.
